// File: rtl/fifo_sync_param.sv
// Single-clock parametrised FIFO with registered or FWFT read,
// occupancy count, watermarks, sticky error flags and flush.
module fifo_sync_param #(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 16,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 1,
  localparam int ADDR    = $clog2(DEPTH)
) (
  input  logic              clk1,
  input  logic              reset,
  input  logic              flush,
  input  logic              w_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              r_en,
  output logic [DATA_W-1:0] data_out,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR:0]     count,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [ADDR:0] CNT_FULL = (ADDR+1)'(DEPTH);
  localparam logic [ADDR:0] CNT_AF   = (ADDR+1)'(AF_LEVEL);
  localparam logic [ADDR:0] CNT_AE   = (ADDR+1)'(AE_LEVEL);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("fifo_sync_param: DEPTH must be a power of 2, >= 2");
  end
  if (AF_LEVEL > DEPTH) begin : g_bad_af
    $error("fifo_sync_param: AF_LEVEL must not exceed DEPTH");
  end
  if (AE_LEVEL >= DEPTH) begin : g_bad_ae
    $error("fifo_sync_param: AE_LEVEL must be below DEPTH");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR-1:0]   w_pt;
  logic [ADDR-1:0]   r_pt;
  logic [ADDR:0]     cnt;
  logic              ovf_q;
  logic              unf_q;
  logic              rd_ok;
  logic              wr_ok;
  logic              live;

  // Status flags decode straight from the registered count.
  always_comb begin
    full         = (cnt == CNT_FULL);
    empty        = (cnt == '0);
    almost_full  = (cnt >= CNT_AF);
    almost_empty = (cnt <= CNT_AE);
    count        = cnt;
    overflow     = ovf_q;
    underflow    = unf_q;
    live         = reset && !flush;
    rd_ok        = r_en && !empty;
    wr_ok        = w_en && (!full || rd_ok);
  end

  // Pointers, occupancy and sticky errors; reset/flush discard
  // anything offered in the same cycle.
  always_ff @(posedge clk1) begin
    if (!live) begin
      w_pt  <= '0;
      r_pt  <= '0;
      cnt   <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (wr_ok) w_pt <= w_pt + ADDR'(1);
      if (rd_ok) r_pt <= r_pt + ADDR'(1);
      unique case ({wr_ok, rd_ok})
        2'b10:   cnt <= cnt + (ADDR+1)'(1);
        2'b01:   cnt <= cnt - (ADDR+1)'(1);
        default: cnt <= cnt;
      endcase
      if (w_en && !wr_ok) ovf_q <= 1'b1;
      if (r_en && !rd_ok) unf_q <= 1'b1;
    end
  end

  // Storage array; contents survive reset and flush.
  always_ff @(posedge clk1) begin
    if (live && wr_ok) mem[w_pt] <= data_in;
  end

  if (FWFT != 0) begin : g_fwft
    // Head word is visible as soon as the FIFO is non-empty.
    always_comb begin
      data_out = empty ? '0 : mem[r_pt];
    end
  end else begin : g_reg
    logic [DATA_W-1:0] dout_q;

    // Registered read: word lands one cycle after the accepted pop;
    // flush keeps the last word on the output.
    always_ff @(posedge clk1) begin
      if (!reset) begin
        dout_q <= '0;
      end else if (!flush && rd_ok) begin
        dout_q <= mem[r_pt];
      end
    end

    always_comb begin
      data_out = dout_q;
    end
  end

endmodule
